instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit_pkg.sv | 24 ++
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit_branch_target_calc.sv | 27 ++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: branch opcodes,
// fetch FSM states and instruction field positions.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    BR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory and datapath signals seen by the fetch unit; the fetch
// unit is the master, the memory/datapath side is the slave.
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH = 4
);

  logic [PC_WIDTH-1:0] prog_counter;
  logic [31:0]         instruction;
  logic [31:0]         instr_out;
  logic                instr_valid;
  logic                stall;
  logic                cmp_valid;
  logic                rs_eq_rt;

  modport master (
    output prog_counter, instr_out, instr_valid,
    input  instruction, stall, cmp_valid, rs_eq_rt
  );

  modport slave (
    input  prog_counter, instr_out, instr_valid,
    output instruction, stall, cmp_valid, rs_eq_rt
  );

endinterface

// File: rtl/instr_fetch_unit_branch_target_calc.sv
// Next-PC computation: PC+1, plus the sign-extended immediate when a branch
// is taken, wrapped to PC_WIDTH bits and flagged when outside the program.
module instr_fetch_unit_branch_target_calc #(
  parameter int PC_WIDTH = 4,
  parameter int PROG_LEN = 11
) (
  input  logic                i_pc_dummy_unused,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic signed [15:0]  i_imm16,
  input  logic                i_taken,
  output logic [PC_WIDTH-1:0] o_next_pc,
  output logic                o_out_of_range
);

  logic signed [15:0] w_offset;
  logic [15:0]        w_sum;
  logic               w_unused_hi;

  assign w_offset = i_taken ? i_imm16 : 16'sd0;

  // Modulo arithmetic: only the low PC_WIDTH bits of the 16-bit sum matter.
  assign w_sum          = 16'(i_pc) + 16'd1 + $unsigned(w_offset);
  assign o_next_pc      = w_sum[PC_WIDTH-1:0];
  assign o_out_of_range = int'(o_next_pc) >= PROG_LEN;
  assign w_unused_hi    = ^{w_sum, i_pc_dummy_unused};

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks the PC through instruction memory, issues one
// word per cycle, waits on the datapath compare for beq/bne, halts past PROG_LEN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH  = 4,
  parameter int PROG_LEN  = 11,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  instr_fetch_unit_if.master   fetch,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] issue_count
);

  state_t               r_state;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [31:0]          r_instr;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_fetch_branch;
  logic                 w_wait_beq;
  logic                 w_taken;
  logic [PC_WIDTH-1:0]  w_next_pc;
  logic                 w_next_oor;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_fetch_branch = is_branch(fetch.instruction[OPC_MSB:OPC_LSB]);
  assign w_wait_beq     = (r_instr[OPC_MSB:OPC_LSB] == OP_BEQ);

  // The held branch in r_instr decides the sense of the compare; outside
  // BR_WAIT the calculator simply yields PC+1.
  assign w_taken = (r_state == BR_WAIT) &&
                   (w_wait_beq ? fetch.rs_eq_rt : !fetch.rs_eq_rt);

  instr_fetch_unit_branch_target_calc #(
    .PC_WIDTH (PC_WIDTH),
    .PROG_LEN (PROG_LEN)
  ) u_target (
    .i_pc_dummy_unused (1'b0),
    .i_pc              (r_pc),
    .i_imm16           (r_instr[IMM_MSB:IMM_LSB]),
    .i_taken           (w_taken),
    .o_next_pc         (w_next_pc),
    .o_out_of_range    (w_next_oor)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        FETCH: begin
          if (!fetch.stall) begin
            r_instr <= fetch.instruction;
            r_valid <= 1'b1;
            r_cnt   <= sat_inc(r_cnt);
            if (w_fetch_branch) begin
              r_state <= BR_WAIT;
            end else if (w_next_oor) begin
              // PC keeps its last in-range value while DONE.
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_pc <= w_next_pc;
            end
          end
        end
        BR_WAIT: begin
          if (fetch.cmp_valid) begin
            if (w_next_oor) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= FETCH;
              r_pc    <= w_next_pc;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fetch.prog_counter = r_pc;
  assign fetch.instr_out    = r_instr;
  assign fetch.instr_valid  = r_valid;
  assign busy               = r_busy;
  assign done               = r_done;
  assign issue_count        = r_cnt;

endmodule
